// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// md_unit : fixed-latency multiply/divide unit owning HI/LO, with mthi/mtlo.
// Revision: 1.0
// ============================================================================
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic        Req,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        RdHi,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MD_Out
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]    state;
  logic [CW-1:0] count;
  logic [31:0]   hi_q;
  logic [31:0]   lo_q;
  logic [31:0]   pend_hi;
  logic [31:0]   pend_lo;
  logic          pend_wr;

  logic          idle;
  logic          accept;
  logic          is_mul;
  logic          wr_hi;
  logic          wr_lo;
  logic [CW-1:0] load_count;

  logic [63:0]   prod_s;
  logic [63:0]   prod_u;
  logic [31:0]   a_mag;
  logic [31:0]   b_mag;
  logic [31:0]   div_a;
  logic [31:0]   div_b;
  logic [31:0]   quo_u;
  logic [31:0]   rem_u;
  logic          neg_quo;
  logic          neg_rem;
  logic [31:0]   res_hi;
  logic [31:0]   res_lo;

  assign idle   = (state == ST_IDLE);
  assign accept = Start && !Req && idle &&
                  (MDOp == OP_MULT || MDOp == OP_MULTU ||
                   MDOp == OP_DIV  || MDOp == OP_DIVU);
  assign is_mul = (MDOp == OP_MULT) || (MDOp == OP_MULTU);
  assign wr_hi  = !Req && idle && (MDOp == OP_MTHI);
  assign wr_lo  = !Req && idle && (MDOp == OP_MTLO);

  assign load_count = is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);

  // Sign-extended 64-bit operands give the signed product in the low 64 bits.
  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Signed division runs on magnitudes; signs are restored afterwards so the
  // quotient truncates toward zero and the remainder follows the dividend.
  assign a_mag   = A[31] ? (32'd0 - A) : A;
  assign b_mag   = B[31] ? (32'd0 - B) : B;
  assign div_a   = (MDOp == OP_DIV) ? a_mag : A;
  assign div_b   = (B == 32'd0) ? 32'd1 : ((MDOp == OP_DIV) ? b_mag : B);
  assign quo_u   = div_a / div_b;
  assign rem_u   = div_a % div_b;
  assign neg_quo = (MDOp == OP_DIV) && (A[31] ^ B[31]);
  assign neg_rem = (MDOp == OP_DIV) && A[31];

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (MDOp)
      OP_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      OP_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      OP_DIV, OP_DIVU: begin
        res_hi = neg_rem ? (32'd0 - rem_u) : rem_u;
        res_lo = neg_quo ? (32'd0 - quo_u) : quo_u;
      end
      default: begin
        res_hi = 32'd0;
        res_lo = 32'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      count   <= '0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_wr <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state   <= ST_BUSY;
            count   <= load_count;
            pend_hi <= res_hi;
            pend_lo <= res_lo;
            // A zero divisor still occupies the unit but must not touch HI/LO.
            pend_wr <= is_mul || (B != 32'd0);
          end else begin
            if (wr_hi) begin
              hi_q <= A;
            end
            if (wr_lo) begin
              lo_q <= A;
            end
          end
        end
        ST_BUSY: begin
          if (count == CW'(1)) begin
            state <= ST_IDLE;
            count <= '0;
            if (pend_wr) begin
              hi_q <= pend_hi;
              lo_q <= pend_lo;
            end
          end else begin
            count <= count - CW'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          count <= '0;
        end
      endcase
    end
  end

  assign Busy   = (state == ST_BUSY);
  assign HI     = hi_q;
  assign LO     = lo_q;
  assign MD_Out = RdHi ? hi_q : lo_q;

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
// tb_md_unit : vector table plus scoreboard bench for md_unit.
// Revision: 1.0
// ============================================================================
module tb_md_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk;
  logic        reset_n;
  logic        Start;
  logic [2:0]  MDOp;
  logic        Req;
  logic [31:0] A;
  logic [31:0] B;
  logic        RdHi;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MD_Out;

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .Start   (Start),
    .MDOp    (MDOp),
    .Req     (Req),
    .A       (A),
    .B       (B),
    .RdHi    (RdHi),
    .Busy    (Busy),
    .HI      (HI),
    .LO      (LO),
    .MD_Out  (MD_Out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  vec_t vecs[9];
  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Called at a negedge; holds the inputs across one rising edge.
  task automatic drive_cycle(input logic st, input logic [2:0] op, input logic rq,
                             input logic [31:0] a, input logic [31:0] b);
    Start = st; MDOp = op; Req = rq; A = a; B = b;
    @(negedge clk);
    Start = 1'b0; MDOp = 3'd0; Req = 1'b0; A = 32'd0; B = 32'd0;
  endtask

  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (Busy && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic check_out(input logic [31:0] hi, input logic [31:0] lo);
    RdHi = 1'b1; #1;
    check("md_out_hi", MD_Out, hi);
    RdHi = 1'b0; #1;
    check("md_out_lo", MD_Out, lo);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hi, input logic [31:0] lo);
    exp_t        e;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    int          cnt;
    logic        stable;
    e.hi  = hi;
    e.lo  = lo;
    e.cyc = (op == 3'd1 || op == 3'd2) ? MC : DC;
    sb.push_back(e);
    pre_hi = HI;
    pre_lo = LO;
    drive_cycle(1'b1, op, 1'b0, a, b);
    cnt    = 0;
    stable = 1'b1;
    while (Busy && cnt < 100) begin
      cnt++;
      if (HI !== pre_hi || LO !== pre_lo) stable = 1'b0;
      @(negedge clk);
    end
    e = sb.pop_front();
    check("busy_cycles", cnt, e.cyc);
    check("hold_during_busy", {31'd0, stable}, 32'd1);
    check("hi", HI, e.hi);
    check("lo", LO, e.lo);
    check_out(e.hi, e.lo);
  endtask

  initial begin
    int cnt;

    vecs[0] = '{3'd1, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[1] = '{3'd2, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE};
    vecs[2] = '{3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{3'd4, 32'd7,        32'd2,        32'd1,        32'd3};
    vecs[4] = '{3'd1, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'd0,        32'd15};
    vecs[5] = '{3'd3, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    vecs[6] = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};
    vecs[7] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[8] = '{3'd4, 32'hFFFFFFFF, 32'd10,       32'd5,        32'h19999999};

    reset_n = 1'b0; Start = 1'b0; MDOp = 3'd0; Req = 1'b0;
    A = 32'd0; B = 32'd0; RdHi = 1'b0;
    #1;
    check("reset_busy", {31'd0, Busy}, 32'd0);
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Asynchronous reset in the middle of a multiply.
    drive_cycle(1'b1, 3'd1, 1'b0, 32'd3, 32'd4);
    @(negedge clk);
    check("busy_before_reset", {31'd0, Busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("async_reset_busy", {31'd0, Busy}, 32'd0);
    check("async_reset_hi", HI, 32'd0);
    check("async_reset_lo", LO, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    check("abandoned_lo", LO, 32'd0);

    foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

    // Divide by zero leaves preloaded HI/LO in place.
    drive_cycle(1'b0, 3'd5, 1'b0, 32'h11, 32'd0);
    drive_cycle(1'b0, 3'd6, 1'b0, 32'h22, 32'd0);
    check("mthi", HI, 32'h11);
    check("mtlo", LO, 32'h22);
    check("mt_busy", {31'd0, Busy}, 32'd0);
    run_op(3'd3, 32'd5, 32'd0, 32'h11, 32'h22);

    // Req blocks both accept and mtlo.
    drive_cycle(1'b1, 3'd1, 1'b1, 32'd2, 32'd3);
    check("req_no_busy", {31'd0, Busy}, 32'd0);
    repeat (MC) @(negedge clk);
    check("req_hi", HI, 32'h11);
    check("req_lo", LO, 32'h22);
    drive_cycle(1'b0, 3'd6, 1'b1, 32'h55, 32'd0);
    check("req_mtlo", LO, 32'h22);

    // Req during Busy does not cancel.
    drive_cycle(1'b1, 3'd1, 1'b0, 32'd2, 32'd3);
    @(negedge clk);
    Req = 1'b1;
    @(negedge clk);
    Req = 1'b0;
    wait_idle(cnt);
    check("req_busy_cycles", cnt + 2, MC);
    check("req_busy_lo", LO, 32'd6);
    check("req_busy_hi", HI, 32'd0);

    // Start and mthi while busy are ignored; then back-to-back mult.
    drive_cycle(1'b1, 3'd3, 1'b0, 32'd100, 32'd7);
    drive_cycle(1'b1, 3'd1, 1'b0, 32'd9, 32'd9);
    drive_cycle(1'b0, 3'd5, 1'b0, 32'h99, 32'd0);
    wait_idle(cnt);
    check("ignore_busy_cycles", cnt + 2, DC);
    check("ignore_hi", HI, 32'd2);
    check("ignore_lo", LO, 32'd14);
    run_op(3'd1, 32'd2, 32'd3, 32'd0, 32'd6);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
